// File: rtl/bus_transceiver_reg_if.sv
// Bus bundle for bus_transceiver_reg: control inputs plus both data ports.
//   oe_n, dir     : transfer enable (active low) and direction (1: A->B)
//   a_in, b_in    : data arriving from ports A and B
//   a_out, b_out  : data to drive onto ports A and B
//   a_oe, b_oe    : per-port drive enables for the pad ring
//   busy          : high while a direction reversal is being served
// Modports: master (bus controller/pads side), slave (transceiver side).
interface bus_transceiver_reg_if #(
  parameter int unsigned WIDTH = 8
);

  logic             oe_n;
  logic             dir;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] a_out;
  logic             a_oe;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] b_out;
  logic             b_oe;
  logic             busy;

  modport master (
    output oe_n,
    output dir,
    output a_in,
    output b_in,
    input  a_out,
    input  a_oe,
    input  b_out,
    input  b_oe,
    input  busy
  );

  modport slave (
    input  oe_n,
    input  dir,
    input  a_in,
    input  b_in,
    output a_out,
    output a_oe,
    output b_out,
    output b_oe,
    output busy
  );

endinterface

// File: rtl/bus_transceiver_reg.sv
// Registered bidirectional bus transceiver ('245 successor) with
// break-before-make direction reversal. No internal tristates: each port has
// separate in/out/oe and the pad ring resolves the wires.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_transceiver_reg_if.slave (oe_n, dir, a_in/a_out/a_oe,
//           b_in/b_out/b_oe, busy)
// Parameters:
//   WIDTH       : data width of ports A and B
//   TURN_CYCLES : dead cycles (both oe low) on a direction reversal, >= 1
// Build option:
//   XCVR_LATCH_EN defined   : a_out/b_out hold their last driven value when
//                             the matching oe drops.
//   XCVR_LATCH_EN undefined : a_out/b_out are 0 whenever their oe is 0.
module bus_transceiver_reg #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  bus_transceiver_reg_if.slave  bus
);

  localparam int unsigned CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DRV_AB = 2'd1,
    ST_DRV_BA = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_oe_q, a_oe_d;
  logic             b_oe_q, b_oe_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;

  // State, counter and all outputs register together so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      a_oe_q  <= 1'b0;
      b_oe_q  <= 1'b0;
      busy_q  <= 1'b0;
      a_out_q <= '0;
      b_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_oe_q  <= a_oe_d;
      b_oe_q  <= b_oe_d;
      busy_q  <= busy_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
    end
  end

  // Next state and next outputs; outputs follow the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_oe_d  = 1'b0;
    b_oe_d  = 1'b0;
    busy_d  = 1'b0;
    a_out_d = '0;
    b_out_d = '0;

    unique case (state_q)
      ST_OFF: begin
        // Nothing is driving, so engaging needs no dead time.
        if (!bus.oe_n) begin
          state_d = bus.dir ? ST_DRV_AB : ST_DRV_BA;
        end
      end
      ST_DRV_AB: begin
        // Release wins over a simultaneous direction flip.
        if (bus.oe_n) begin
          state_d = ST_OFF;
        end else if (!bus.dir) begin
          state_d = ST_TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      ST_DRV_BA: begin
        if (bus.oe_n) begin
          state_d = ST_OFF;
        end else if (bus.dir) begin
          state_d = ST_TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      ST_TURN: begin
        // dir is only looked at on the exit edge; the dead time is always
        // served in full, even if dir ends up back where it started.
        if (bus.oe_n) begin
          state_d = ST_OFF;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = bus.dir ? ST_DRV_AB : ST_DRV_BA;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    b_oe_d = (state_d == ST_DRV_AB);
    a_oe_d = (state_d == ST_DRV_BA);
    busy_d = (state_d == ST_TURN);

`ifdef XCVR_LATCH_EN
    a_out_d = a_oe_d ? bus.b_in : a_out_q;
    b_out_d = b_oe_d ? bus.a_in : b_out_q;
`else
    a_out_d = a_oe_d ? bus.b_in : '0;
    b_out_d = b_oe_d ? bus.a_in : '0;
`endif
  end

  assign bus.a_oe  = a_oe_q;
  assign bus.b_oe  = b_oe_q;
  assign bus.busy  = busy_q;
  assign bus.a_out = a_out_q;
  assign bus.b_out = b_out_q;

  // The two ports must never be driven in the same cycle.
  a_b_oe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(a_oe_q && b_oe_q));

endmodule

// File: tb/tb_bus_transceiver_reg.sv
// Self-checking bench for bus_transceiver_reg (WIDTH=8, TURN_CYCLES=2).
// A cycle model predicts outputs for each driven cycle; predictions are queued
// when stimulus is applied and popped/compared after the clock edge.
module tb_bus_transceiver_reg;

  localparam int unsigned W    = 8;
  localparam int unsigned TURN = 2;

  localparam int M_OFF  = 0;
  localparam int M_AB   = 1;
  localparam int M_BA   = 2;
  localparam int M_TURN = 3;

`ifdef XCVR_LATCH_EN
  localparam logic [W-1:0] B_AFTER_TURN = 8'hA5;
`else
  localparam logic [W-1:0] B_AFTER_TURN = 8'h00;
`endif

  typedef struct packed {
    logic         a_oe;
    logic         b_oe;
    logic         busy;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
  } obs_t;

  logic clk;
  logic rst_n;

  bus_transceiver_reg_if #(.WIDTH(W)) bus ();

  bus_transceiver_reg #(.WIDTH(W), .TURN_CYCLES(TURN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  obs_t exp_q[$];

  int           m_st   = M_OFF;
  int           m_left = 0;
  logic [W-1:0] m_a_out = '0;
  logic [W-1:0] m_b_out = '0;

  function automatic obs_t observe();
    obs_t o;
    o.a_oe  = bus.a_oe;
    o.b_oe  = bus.b_oe;
    o.busy  = bus.busy;
    o.a_out = bus.a_out;
    o.b_out = bus.b_out;
    return o;
  endfunction

  task automatic model_reset();
    m_st    = M_OFF;
    m_left  = 0;
    m_a_out = '0;
    m_b_out = '0;
    exp_q.delete();
  endtask

  // Apply one cycle of stimulus, queue the prediction, advance past the edge.
  task automatic cycle(input logic oe_n_v, input logic dir_v,
                       input logic [W-1:0] a_v, input logic [W-1:0] b_v);
    obs_t e;
    int   nxt;
    bus.oe_n = oe_n_v;
    bus.dir  = dir_v;
    bus.a_in = a_v;
    bus.b_in = b_v;
    nxt = m_st;
    case (m_st)
      M_OFF:  if (!oe_n_v) nxt = dir_v ? M_AB : M_BA;
      M_AB: begin
        if (oe_n_v) nxt = M_OFF;
        else if (!dir_v) begin nxt = M_TURN; m_left = TURN; end
      end
      M_BA: begin
        if (oe_n_v) nxt = M_OFF;
        else if (dir_v) begin nxt = M_TURN; m_left = TURN; end
      end
      default: begin
        if (oe_n_v) nxt = M_OFF;
        else if (m_left > 1) m_left = m_left - 1;
        else nxt = dir_v ? M_AB : M_BA;
      end
    endcase
    m_st = nxt;
`ifdef XCVR_LATCH_EN
    if (m_st == M_AB) m_b_out = a_v;
    if (m_st == M_BA) m_a_out = b_v;
`else
    m_b_out = (m_st == M_AB) ? a_v : '0;
    m_a_out = (m_st == M_BA) ? b_v : '0;
`endif
    e.a_oe  = (m_st == M_BA);
    e.b_oe  = (m_st == M_AB);
    e.busy  = (m_st == M_TURN);
    e.a_out = m_a_out;
    e.b_out = m_b_out;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    bus.oe_n = 1'b1;
    bus.dir  = 1'b1;
    bus.a_in = 8'hFF;
    bus.b_in = 8'hFF;
    rst_n    = 1'b0;
    model_reset();
    #12;
    o = observe();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", o, obs_t'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'hFF, 8'hFF);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e || o !== obs_t'(0)) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_drive_ab();
    logic [W-1:0] data [3];
    obs_t o, e;
    data[0] = 8'hA5; data[1] = 8'hC3; data[2] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, data[i], 8'h11);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e || !o.b_oe || o.a_oe || o.b_out !== data[i]) begin
        n_err++;
        $display("FAIL drive_ab[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_turn();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h77, 8'h3C);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL turn_model[%0d]: got %h expected %h", i, o, e);
      end
      n_cmp++;
      if (i < 2 && (!o.busy || o.a_oe || o.b_oe || o.b_out !== B_AFTER_TURN)) begin
        n_err++;
        $display("FAIL turn_dead[%0d]: got busy=%b a_oe=%b b_oe=%b b_out=%h expected 1 0 0 %h",
                 i, o.busy, o.a_oe, o.b_oe, o.b_out, B_AFTER_TURN);
      end else if (i == 2 && (o.busy || !o.a_oe || o.b_oe || o.a_out !== 8'h3C ||
                              o.b_out !== B_AFTER_TURN)) begin
        n_err++;
        $display("FAIL turn_exit: got busy=%b a_oe=%b b_oe=%b a_out=%h b_out=%h expected 0 1 0 3c %h",
                 o.busy, o.a_oe, o.b_oe, o.a_out, o.b_out, B_AFTER_TURN);
      end
    end
  endtask

  // From DRV_BA start a reversal, then wander dir inside TURN and exit back to BA.
  task automatic test_turn_dir_glitch();
    logic dirs [3];
    obs_t o, e;
    int   dead;
    dirs[0] = 1'b1; dirs[1] = 1'b0; dirs[2] = 1'b0;
    dead = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, dirs[i], 8'h00, 8'h5A + 8'(i));
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL glitch_model[%0d]: got %h expected %h", i, o, e);
      end
      if (!o.a_oe && !o.b_oe) dead++;
    end
    n_cmp++;
    if (dead != TURN || !bus.a_oe || bus.a_out !== 8'h5C) begin
      n_err++;
      $display("FAIL glitch_dead: got dead=%0d a_oe=%b a_out=%h expected %0d 1 5c",
               dead, bus.a_oe, bus.a_out, TURN);
    end
  endtask

  // Release and direction flip on the same edge: OFF, no busy pulse.
  task automatic test_release_wins();
    obs_t o, e;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cycle(1'b1, 1'b1, 8'h96, 8'h69);
      else       cycle(1'b0, 1'b1, 8'h96, 8'h69);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL release_model[%0d]: got %h expected %h", i, o, e);
      end
      n_cmp++;
      if (i < 2 && (o.busy || o.a_oe || o.b_oe)) begin
        n_err++;
        $display("FAIL release_off[%0d]: got busy=%b a_oe=%b b_oe=%b expected 0 0 0",
                 i, o.busy, o.a_oe, o.b_oe);
      end else if (i == 2 && (!o.b_oe || o.busy || o.b_out !== 8'h96)) begin
        n_err++;
        $display("FAIL off_to_drv: got b_oe=%b busy=%b b_out=%h expected 1 0 96",
                 o.b_oe, o.busy, o.b_out);
      end
    end
  endtask

  task automatic test_reset_mid_turn();
    obs_t o, e;
    cycle(1'b0, 1'b0, 8'h00, 8'hE7);
    e = exp_q.pop_front();
    o = observe();
    n_cmp++;
    if (o !== e || !o.busy) begin
      n_err++;
      $display("FAIL mid_turn_entry: got %h expected %h", o, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = observe();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", o, obs_t'(0));
    end
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) cycle(1'b1, 1'b0, 8'h42, 8'h24);
      else        cycle(1'b0, 1'b0, 8'h42, 8'h24);
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL post_reset_model[%0d]: got %h expected %h", i, o, e);
      end
    end
    // Starting from OFF the first engage must drive immediately.
    n_cmp++;
    if (!bus.a_oe || bus.busy || bus.a_out !== 8'h24) begin
      n_err++;
      $display("FAIL post_reset_off: got a_oe=%b busy=%b a_out=%h expected 1 0 24",
               bus.a_oe, bus.busy, bus.a_out);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic oe_n_v, dir_v;
    int   last_port, gap, busy_gap, n_rev;
    dir_v = 1'b0;
    last_port = 0; gap = 0; busy_gap = 0; n_rev = 0;
    for (int i = 0; i < 10000; i++) begin
      oe_n_v = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) dir_v = ~dir_v;
      cycle(oe_n_v, dir_v, 8'($urandom), 8'($urandom));
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random_model[%0d]: got %h expected %h", i, o, e);
      end
      n_cmp++;
      if (o.a_oe && o.b_oe) begin
        n_err++;
        $display("FAIL random_oe_overlap[%0d]: got a_oe=%b b_oe=%b expected not both 1",
                 i, o.a_oe, o.b_oe);
      end
      if (o.a_oe || o.b_oe) begin
        // A reversal served purely by TURN must show exactly the dead time.
        if (last_port != 0 && (o.b_oe ? 1 : 2) != last_port &&
            busy_gap > 0 && busy_gap == gap) begin
          n_rev++;
          n_cmp++;
          if (gap != TURN) begin
            n_err++;
            $display("FAIL random_dead[%0d]: got %0d dead cycles expected %0d", i, gap, TURN);
          end
        end
        last_port = o.b_oe ? 1 : 2;
        gap = 0;
        busy_gap = 0;
      end else begin
        gap++;
        if (o.busy) busy_gap++;
      end
    end
    n_cmp++;
    if (n_rev == 0) begin
      n_err++;
      $display("FAIL random_reversals: got %0d reversals expected > 0", n_rev);
    end
  endtask

  initial begin
    test_reset();
    test_drive_ab();
    test_turn();
    test_turn_dir_glitch();
    test_release_wins();
    test_reset_mid_turn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
